// File: rtl/game_flow_controller_pkg.sv
// Shared state encodings and limits for the game sequencer and its watchdog.
package game_flow_controller_pkg;

  typedef enum logic [2:0] {
    GAME_IDLE    = 3'd0,
    GAME_PLAYING = 3'd1,
    GAME_VICTORY = 3'd2,
    GAME_DEFEAT  = 3'd3,
    GAME_ERROR   = 3'd4
  } game_state_e;

  typedef enum logic [2:0] {
    ONPLAY_DRAW      = 3'd0,
    ONPLAY_CALCVALUE = 3'd1,
    ONPLAY_MOVE      = 3'd2,
    ONPLAY_COLLISION = 3'd3,
    ONPLAY_CHECKING  = 3'd4,
    ONPLAY_WAITING   = 3'd5
  } onplay_state_e;

  localparam logic [1:0] PHASE_1 = 2'd0;
  localparam logic [1:0] PHASE_2 = 2'd1;
  localparam logic [1:0] PHASE_3 = 2'd2;
  localparam logic [1:0] PHASE_4 = 2'd3;

  localparam int MAX_PHASE_CNT = 124;
  localparam int MAX_ENEMY     = 15;

  // Stages that hand work to an external unit and wait for its done strobe.
  function automatic logic is_stage(input onplay_state_e s);
    return (s == ONPLAY_CALCVALUE) || (s == ONPLAY_MOVE) || (s == ONPLAY_COLLISION);
  endfunction

endpackage

// File: rtl/game_flow_controller_stage_watchdog.sv
// Cycle counter for one unit stage; terminal marks the last cycle a stage may last.
module stage_watchdog #(
  parameter int CNT_W = 10,
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: game FSM plus per-frame on-play pipeline driving calc/move/collision units.
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int PHASE_FRAMES  = MAX_PHASE_CNT,
  parameter int STAGE_TIMEOUT = 1023,
  parameter int CNT_W         = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       vblank_start,
  input  logic       frame_start,
  input  logic       calc_done,
  input  logic       move_done,
  input  logic       coll_done,
  input  logic [3:0] enemy_alive,
  input  logic       player_hit,
  output logic       calc_start,
  output logic       move_start,
  output logic       coll_start,
  output logic [2:0] game_state,
  output logic [2:0] onplay_state,
  output logic [1:0] phase,
  output logic       frame_overrun
);

  localparam int FRAME_W = $clog2(PHASE_FRAMES);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(PHASE_FRAMES - 1);

  game_state_e        game_q;
  onplay_state_e      op_q;
  logic [1:0]         phase_q;
  logic [FRAME_W-1:0] frame_cnt;
  logic               calc_start_q;
  logic               move_start_q;
  logic               coll_start_q;
  logic               overrun_q;

  logic playing;
  logic in_stage;
  logic done_acc;
  logic wd_terminal;
  logic wd_clear;
  logic timeout;
  logic restart;

  // Unit handshake: start is a 1-cycle pulse in the first stage cycle; the matching
  // done is honoured only in that stage and never in the start cycle itself.
  assign playing  = (game_q == GAME_PLAYING);
  assign in_stage = playing && is_stage(op_q);
  assign done_acc = playing &&
                    (((op_q == ONPLAY_CALCVALUE) && calc_done && !calc_start_q) ||
                     ((op_q == ONPLAY_MOVE)      && move_done && !move_start_q) ||
                     ((op_q == ONPLAY_COLLISION) && coll_done && !coll_start_q));
  assign wd_clear = !in_stage || done_acc;
  assign timeout  = in_stage && wd_terminal && !done_acc;
  assign restart  = (game_q == GAME_IDLE) && start_btn;

  stage_watchdog #(
    .CNT_W (CNT_W),
    .LIMIT (STAGE_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (wd_clear),
    .enable   (in_stage),
    .terminal (wd_terminal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      game_q <= GAME_IDLE;
    end else begin
      case (game_q)
        GAME_IDLE: if (start_btn) game_q <= GAME_PLAYING;
        GAME_PLAYING: begin
          if (op_q == ONPLAY_CHECKING) begin
            if (player_hit)                game_q <= GAME_DEFEAT;
            else if (enemy_alive == 4'd0)  game_q <= GAME_VICTORY;
          end else if (timeout) begin
            game_q <= GAME_ERROR;
          end
        end
        GAME_VICTORY, GAME_DEFEAT, GAME_ERROR: if (start_btn) game_q <= GAME_IDLE;
        default: game_q <= GAME_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q         <= ONPLAY_DRAW;
      phase_q      <= PHASE_1;
      frame_cnt    <= '0;
      calc_start_q <= 1'b0;
      move_start_q <= 1'b0;
      coll_start_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      calc_start_q <= 1'b0;
      move_start_q <= 1'b0;
      coll_start_q <= 1'b0;
      // A late vblank is flagged and dropped; the frame in flight carries on.
      overrun_q    <= playing && vblank_start && (op_q != ONPLAY_DRAW);
      if (restart) begin
        op_q      <= ONPLAY_DRAW;
        phase_q   <= PHASE_1;
        frame_cnt <= '0;
      end else if (!playing || timeout) begin
        op_q <= ONPLAY_DRAW;
      end else begin
        case (op_q)
          ONPLAY_DRAW: begin
            if (vblank_start) begin
              op_q         <= ONPLAY_CALCVALUE;
              calc_start_q <= 1'b1;
            end
          end
          ONPLAY_CALCVALUE: begin
            if (done_acc) begin
              op_q         <= ONPLAY_MOVE;
              move_start_q <= 1'b1;
            end
          end
          ONPLAY_MOVE: begin
            if (done_acc) begin
              op_q         <= ONPLAY_COLLISION;
              coll_start_q <= 1'b1;
            end
          end
          ONPLAY_COLLISION: if (done_acc) op_q <= ONPLAY_CHECKING;
          ONPLAY_CHECKING: begin
            if (frame_cnt == LAST_FRAME) begin
              frame_cnt <= '0;
              if (phase_q != PHASE_4) phase_q <= phase_q + 2'd1;
            end else begin
              frame_cnt <= frame_cnt + FRAME_W'(1);
            end
            if (player_hit || (enemy_alive == 4'd0)) op_q <= ONPLAY_DRAW;
            else                                     op_q <= ONPLAY_WAITING;
          end
          ONPLAY_WAITING: if (frame_start) op_q <= ONPLAY_DRAW;
          default: op_q <= ONPLAY_DRAW;
        endcase
      end
    end
  end

  assign calc_start    = calc_start_q;
  assign move_start    = move_start_q;
  assign coll_start    = coll_start_q;
  assign game_state    = game_q;
  assign onplay_state  = op_q;
  assign phase         = phase_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed sequence with randomized unit latencies, stray strobes and enemy counts,
// checked against a frame-level model of the game rules.
module tb_game_flow_controller;
  import game_flow_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_btn, vblank_start, frame_start;
  logic       calc_done, move_done, coll_done;
  logic [3:0] enemy_alive;
  logic       player_hit;
  logic       calc_start, move_start, coll_start;
  logic [2:0] game_state, onplay_state;
  logic [1:0] phase;
  logic       frame_overrun;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [7:0] exp_q[$];
  onplay_state_e stage_op[3] = '{ONPLAY_CALCVALUE, ONPLAY_MOVE, ONPLAY_COLLISION};

  game_flow_controller dut (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .vblank_start(vblank_start),
    .frame_start(frame_start), .calc_done(calc_done), .move_done(move_done),
    .coll_done(coll_done), .enemy_alive(enemy_alive), .player_hit(player_hit),
    .calc_start(calc_start), .move_start(move_start), .coll_start(coll_start),
    .game_state(game_state), .onplay_state(onplay_state), .phase(phase),
    .frame_overrun(frame_overrun)
  );

  // clock / time limit
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL time_limit: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  // phase after n completed frames: one step per 124 frames, stuck at PHASE_4
  function automatic logic [1:0] model_phase(input int n);
    int p = n / MAX_PHASE_CNT;
    return (p > 3) ? 2'd3 : 2'(p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start_btn = 0; vblank_start = 0; frame_start = 0;
    calc_done = 0; move_done = 0; coll_done = 0; player_hit = 0;
    enemy_alive = 4'd5;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [2:0] eg, input logic [2:0] eo,
                            input logic [1:0] eph, input logic ecs, input logic ems,
                            input logic ecol, input logic eovr);
    chk({tag, "_game"}, game_state, eg);
    chk({tag, "_onplay"}, onplay_state, eo);
    chk({tag, "_phase"}, phase, eph);
    chk({tag, "_calc_start"}, calc_start, ecs);
    chk({tag, "_move_start"}, move_start, ems);
    chk({tag, "_coll_start"}, coll_start, ecol);
    chk({tag, "_overrun"}, frame_overrun, eovr);
  endtask

  // Sit in a unit stage for a while, with ignored strobes, then finish it.
  task automatic run_stage(input int unit, input int delay);
    int d;
    d = (delay > 0) ? delay : $urandom_range(1, 4);
    for (int i = 0; i < d; i++) begin
      calc_done   = (unit == 0) ? ((i == 0) ? 1'($urandom_range(0, 1)) : 1'b0) : 1'($urandom_range(0, 1));
      move_done   = (unit == 1) ? ((i == 0) ? 1'($urandom_range(0, 1)) : 1'b0) : 1'($urandom_range(0, 1));
      coll_done   = (unit == 2) ? ((i == 0) ? 1'($urandom_range(0, 1)) : 1'b0) : 1'($urandom_range(0, 1));
      frame_start = 1'($urandom_range(0, 1));
      start_btn   = 1'($urandom_range(0, 1));
      tick();
      clear_inputs();
      expect_all("stage_hold", GAME_PLAYING, stage_op[unit], model_phase(frames), 0, 0, 0, 0);
    end
    calc_done = (unit == 0);
    move_done = (unit == 1);
    coll_done = (unit == 2);
    tick();
    clear_inputs();
  endtask

  task automatic run_frame(input logic hit, input logic [3:0] alive, input int delay);
    logic [2:0] eg, eo;
    logic [1:0] ph;
    int w;
    logic v;
    ph = model_phase(frames);
    vblank_start = 1;
    tick();
    clear_inputs();
    expect_all("vblank", GAME_PLAYING, ONPLAY_CALCVALUE, ph, 1, 0, 0, 0);
    run_stage(0, delay);
    expect_all("calc_done", GAME_PLAYING, ONPLAY_MOVE, ph, 0, 1, 0, 0);
    run_stage(1, delay);
    expect_all("move_done", GAME_PLAYING, ONPLAY_COLLISION, ph, 0, 0, 1, 0);
    run_stage(2, delay);
    expect_all("coll_done", GAME_PLAYING, ONPLAY_CHECKING, ph, 0, 0, 0, 0);
    player_hit = hit;
    enemy_alive = alive;
    tick();
    clear_inputs();
    frames++;
    eg = hit ? GAME_DEFEAT : ((alive == 4'd0) ? GAME_VICTORY : GAME_PLAYING);
    eo = (eg == GAME_PLAYING) ? ONPLAY_WAITING : ONPLAY_DRAW;
    ph = model_phase(frames);
    exp_q.push_back({eg, eo, ph});
    chk("checking_result", {game_state, onplay_state, phase}, exp_q.pop_front());
    chk("checking_starts", {calc_start, move_start, coll_start}, 3'b000);
    if (eg == GAME_PLAYING) begin
      w = $urandom_range(0, 3);
      for (int i = 0; i < w; i++) begin
        v = ($urandom_range(0, 7) == 0);
        vblank_start = v;
        tick();
        clear_inputs();
        expect_all("waiting", GAME_PLAYING, ONPLAY_WAITING, ph, 0, 0, 0, v);
      end
      frame_start = 1;
      tick();
      clear_inputs();
      expect_all("frame_start", GAME_PLAYING, ONPLAY_DRAW, ph, 0, 0, 0, 0);
    end
  endtask

  task automatic press_start(input logic [2:0] eg, input logic [1:0] eph);
    start_btn = 1;
    tick();
    clear_inputs();
    expect_all("start_btn", eg, ONPLAY_DRAW, eph, 0, 0, 0, 0);
  endtask

  initial begin
    clear_inputs();
    // reset wins over active inputs
    rst_n = 0;
    start_btn = 1; vblank_start = 1; calc_done = 1; player_hit = 1;
    tick();
    tick();
    clear_inputs();
    expect_all("reset", GAME_IDLE, ONPLAY_DRAW, PHASE_1, 0, 0, 0, 0);
    rst_n = 1;

    vblank_start = 1; frame_start = 1;
    tick();
    clear_inputs();
    expect_all("idle_ignore", GAME_IDLE, ONPLAY_DRAW, PHASE_1, 0, 0, 0, 0);

    press_start(GAME_PLAYING, PHASE_1);
    frames = 0;
    run_frame(0, 4'd3, 5);

    for (int f = 1; f < 620; f++) begin
      run_frame(0, 4'($urandom_range(1, MAX_ENEMY)), 0);
      if (frames == 124) chk("phase_at_124", phase, PHASE_2);
      if (frames == 496) chk("phase_at_496", phase, PHASE_4);
    end
    chk("phase_at_620", phase, PHASE_4);

    // hit takes priority over zero enemies
    run_frame(1, 4'd0, 0);
    vblank_start = 1; frame_start = 1;
    tick();
    clear_inputs();
    expect_all("defeat_hold", GAME_DEFEAT, ONPLAY_DRAW, model_phase(frames), 0, 0, 0, 0);
    press_start(GAME_IDLE, model_phase(frames));

    press_start(GAME_PLAYING, PHASE_1);
    frames = 0;
    run_frame(0, 4'd0, 0);
    press_start(GAME_IDLE, PHASE_1);

    // stage timeout while move_done is withheld
    press_start(GAME_PLAYING, PHASE_1);
    frames = 0;
    vblank_start = 1;
    tick();
    clear_inputs();
    run_stage(0, 2);
    expect_all("to_move_entry", GAME_PLAYING, ONPLAY_MOVE, PHASE_1, 0, 1, 0, 0);
    repeat (1021) tick();
    expect_all("to_move_wait", GAME_PLAYING, ONPLAY_MOVE, PHASE_1, 0, 0, 0, 0);
    tick();
    expect_all("to_move_last", GAME_PLAYING, ONPLAY_MOVE, PHASE_1, 0, 0, 0, 0);
    tick();
    expect_all("timeout", GAME_ERROR, ONPLAY_DRAW, PHASE_1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      vblank_start = 1'($urandom_range(0, 1));
      move_done = 1'($urandom_range(0, 1));
      calc_done = 1'($urandom_range(0, 1));
      tick();
      clear_inputs();
      expect_all("error_hold", GAME_ERROR, ONPLAY_DRAW, PHASE_1, 0, 0, 0, 0);
    end
    press_start(GAME_IDLE, PHASE_1);

    // late vblank during MOVE, then reset mid-COLLISION
    press_start(GAME_PLAYING, PHASE_1);
    frames = 0;
    vblank_start = 1;
    tick();
    clear_inputs();
    run_stage(0, 0);
    expect_all("ovr_move_entry", GAME_PLAYING, ONPLAY_MOVE, PHASE_1, 0, 1, 0, 0);
    vblank_start = 1;
    tick();
    clear_inputs();
    expect_all("overrun", GAME_PLAYING, ONPLAY_MOVE, PHASE_1, 0, 0, 0, 1);
    tick();
    expect_all("overrun_end", GAME_PLAYING, ONPLAY_MOVE, PHASE_1, 0, 0, 0, 0);
    move_done = 1;
    tick();
    clear_inputs();
    expect_all("ovr_coll_entry", GAME_PLAYING, ONPLAY_COLLISION, PHASE_1, 0, 0, 1, 0);
    tick();
    rst_n = 0; coll_done = 1; start_btn = 1;
    tick();
    clear_inputs();
    expect_all("mid_reset", GAME_IDLE, ONPLAY_DRAW, PHASE_1, 0, 0, 0, 0);
    rst_n = 1;

    press_start(GAME_PLAYING, PHASE_1);
    frames = 0;
    run_frame(0, 4'd7, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
